// File: rtl/mem_arbiter8_if.sv
// ============================================================================
// Module   : mem_arbiter8_if
// Brief    : Master-side request/ack signals and RAM port for mem_arbiter8.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter8_if;
    logic       m0_req;
    logic       m1_req;
    logic       m0_we;
    logic       m1_we;
    logic [7:0] m0_addr;
    logic [7:0] m1_addr;
    logic [7:0] m0_wdata;
    logic [7:0] m1_wdata;
    logic       m0_ack;
    logic       m1_ack;
    logic [7:0] rdata;
    logic       busy;
    logic       gnt_id;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, mem_rdata,
        output m0_ack, m1_ack, rdata, busy, gnt_id,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Environment view: both requesting masters plus the RAM
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, mem_rdata,
        input  m0_ack, m1_ack, rdata, busy, gnt_id,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter8.sv
// ============================================================================
// Module   : mem_arbiter8
// Brief    : Two-master arbiter/sequencer for a single-port 8-bit RAM.
//            Define MEMARB_ROUND_ROBIN_EN for round-robin arbitration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter8 #(
    parameter int WAIT_STATES = 0
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter8_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       op_we, op_we_nxt;
    logic       m0_ack, m0_ack_nxt;
    logic       m1_ack, m1_ack_nxt;
    logic [7:0] rdata, rdata_nxt;
    logic       busy, busy_nxt;
    logic       gnt_id, gnt_id_nxt;
    logic       mem_en, mem_en_nxt;
    logic       mem_we, mem_we_nxt;
    logic [7:0] mem_addr, mem_addr_nxt;
    logic [7:0] mem_wdata, mem_wdata_nxt;
    logic       winner;

`ifdef MEMARB_ROUND_ROBIN_EN
    logic prio, prio_nxt;

    always_comb begin
        winner = (bus.m0_req && bus.m1_req) ? prio : !bus.m0_req;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
        end else begin
            prio <= prio_nxt;
        end
    end
`else
    always_comb begin
        winner = !bus.m0_req;
    end
`endif

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        op_we_nxt     = op_we;
        m0_ack_nxt    = 1'b0;
        m1_ack_nxt    = 1'b0;
        rdata_nxt     = rdata;
        gnt_id_nxt    = gnt_id;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
`ifdef MEMARB_ROUND_ROBIN_EN
        prio_nxt      = prio;
`endif
        case (state)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    gnt_id_nxt    = winner;
                    op_we_nxt     = winner ? bus.m1_we    : bus.m0_we;
                    mem_we_nxt    = winner ? bus.m1_we    : bus.m0_we;
                    mem_addr_nxt  = winner ? bus.m1_addr  : bus.m0_addr;
                    mem_wdata_nxt = winner ? bus.m1_wdata : bus.m0_wdata;
                    mem_en_nxt    = 1'b1;
                    state_nxt     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                wait_cnt_nxt = 4'(WAIT_STATES);
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    // Writes leave rdata holding the last read result
                    if (!op_we) begin
                        rdata_nxt = bus.mem_rdata;
                    end
                    m0_ack_nxt = !gnt_id;
                    m1_ack_nxt = gnt_id;
                    state_nxt  = S_ACK;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_ACK: begin
`ifdef MEMARB_ROUND_ROBIN_EN
                prio_nxt  = !prio;
`endif
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            op_we     <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            rdata     <= 8'h00;
            busy      <= 1'b0;
            gnt_id    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            op_we     <= op_we_nxt;
            m0_ack    <= m0_ack_nxt;
            m1_ack    <= m1_ack_nxt;
            rdata     <= rdata_nxt;
            busy      <= busy_nxt;
            gnt_id    <= gnt_id_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    assign bus.m0_ack    = m0_ack;
    assign bus.m1_ack    = m1_ack;
    assign bus.rdata     = rdata;
    assign bus.busy      = busy;
    assign bus.gnt_id    = gnt_id;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter8.sv
// ============================================================================
// Module   : tb_mem_arbiter8
// Brief    : Self-checking bench; instance d=0 uses WAIT_STATES=0, d=1 uses 3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter8;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter8_if if0 ();
    mem_arbiter8_if if3 ();

    mem_arbiter8 #(.WAIT_STATES(0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    mem_arbiter8 #(.WAIT_STATES(3)) dut3 (.clock(clock), .reset(reset), .bus(if3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM models: read data registered on the mem_en edge
    logic [7:0] mem0 [256];
    logic [7:0] mem3 [256];
    logic [7:0] mrd0 = 8'h00;
    logic [7:0] mrd3 = 8'h00;

    always @(posedge clock) begin
        if (if0.mem_en) begin
            if (if0.mem_we) mem0[if0.mem_addr] <= if0.mem_wdata;
            else            mrd0 <= mem0[if0.mem_addr];
        end
        if (if3.mem_en) begin
            if (if3.mem_we) mem3[if3.mem_addr] <= if3.mem_wdata;
            else            mrd3 <= mem3[if3.mem_addr];
        end
    end
    assign if0.mem_rdata = mrd0;
    assign if3.mem_rdata = mrd3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic m, input logic rq, input logic we,
                         input logic [7:0] a, input logic [7:0] wd);
        if (d == 0) begin
            if (m) begin if0.m1_req = rq; if0.m1_we = we; if0.m1_addr = a; if0.m1_wdata = wd; end
            else   begin if0.m0_req = rq; if0.m0_we = we; if0.m0_addr = a; if0.m0_wdata = wd; end
        end else begin
            if (m) begin if3.m1_req = rq; if3.m1_we = we; if3.m1_addr = a; if3.m1_wdata = wd; end
            else   begin if3.m0_req = rq; if3.m0_we = we; if3.m0_addr = a; if3.m0_wdata = wd; end
        end
    endtask

    function automatic logic g_ack(input int d, input logic m);
        if (d == 0) return m ? if0.m1_ack : if0.m0_ack;
        return m ? if3.m1_ack : if3.m0_ack;
    endfunction
    function automatic logic g_en(input int d);   return (d == 0) ? if0.mem_en   : if3.mem_en;   endfunction
    function automatic logic g_we(input int d);   return (d == 0) ? if0.mem_we   : if3.mem_we;   endfunction
    function automatic logic g_busy(input int d); return (d == 0) ? if0.busy     : if3.busy;     endfunction
    function automatic logic g_gnt(input int d);  return (d == 0) ? if0.gnt_id   : if3.gnt_id;   endfunction
    function automatic logic [7:0] g_addr(input int d);  return (d == 0) ? if0.mem_addr  : if3.mem_addr;  endfunction
    function automatic logic [7:0] g_wdata(input int d); return (d == 0) ? if0.mem_wdata : if3.mem_wdata; endfunction
    function automatic logic [7:0] g_rdata(input int d); return (d == 0) ? if0.rdata     : if3.rdata;     endfunction

    task automatic chk_reset_state(input string tag, input int d);
        chk({tag, "_busy"},   g_busy(d),   0);
        chk({tag, "_mem_en"}, g_en(d),     0);
        chk({tag, "_mem_we"}, g_we(d),     0);
        chk({tag, "_ack0"},   g_ack(d, 0), 0);
        chk({tag, "_ack1"},   g_ack(d, 1), 0);
        chk({tag, "_gnt"},    g_gnt(d),    0);
        chk({tag, "_addr"},   g_addr(d),   8'h00);
        chk({tag, "_wdata"},  g_wdata(d),  8'h00);
        chk({tag, "_rdata"},  g_rdata(d),  8'h00);
    endtask

    // One complete single-master transaction with latency and strobe checks
    task automatic txn(input int d, input logic m, input logic we, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] ex);
        int lat;
        bit got;
        int exp_lat;
        exp_lat = (d == 0) ? 2 : 5;
        @(negedge clock);
        drive(d, m, 1'b1, we, a, wd);
        @(posedge clock); #1;
        chk("access_en",   g_en(d),   1);
        chk("access_we",   g_we(d),   we);
        chk("access_addr", g_addr(d), a);
        chk("access_gnt",  g_gnt(d),  m);
        chk("access_busy", g_busy(d), 1);
        if (we) chk("access_wdata", g_wdata(d), wd);
        got = 0;
        lat = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge clock); #1;
            chk("post_access_en", g_en(d), 0);
            chk("post_access_we", g_we(d), 0);
            chk("other_ack", g_ack(d, !m), 0);
            if (g_ack(d, m)) begin
                got = 1;
                lat = n;
            end
        end
        chk("ack_seen", got, 1);
        chk("ack_latency", lat, exp_lat);
        chk("ack_rdata", g_rdata(d), ex);
        chk("ack_addr_held", g_addr(d), a);
        drive(d, m, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clock); #1;
        chk("ack_pulse_end", g_ack(d, m), 0);
        chk("idle_busy", g_busy(d), 0);
    endtask

    typedef struct {
        int         d;
        logic       m;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int   seq [6];
        int   exp_seq [6];
        int   n;
        int   c0;
        int   c1;

        foreach (mem0[i]) begin mem0[i] = 8'h00; mem3[i] = 8'h00; end
        mem0[8'h10] = 8'hA5;
        mem0[8'h01] = 8'h77;
        mem3[8'h10] = 8'hC3;

        vecs[0] = '{0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[1] = '{0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h77};
        vecs[2] = '{0, 1'b0, 1'b1, 8'h02, 8'hFF, 8'h77};
        vecs[3] = '{0, 1'b1, 1'b0, 8'h02, 8'h00, 8'hFF};
        vecs[4] = '{0, 1'b1, 1'b1, 8'h20, 8'h5A, 8'hFF};
        vecs[5] = '{0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h5A};
        vecs[6] = '{1, 1'b1, 1'b1, 8'h80, 8'h3C, 8'h00};
        vecs[7] = '{1, 1'b1, 1'b0, 8'h80, 8'h00, 8'h3C};
        vecs[8] = '{1, 1'b0, 1'b0, 8'h10, 8'h00, 8'hC3};
        vecs[9] = '{1, 1'b0, 1'b1, 8'h11, 8'h99, 8'hC3};

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(d, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        repeat (2) @(posedge clock);
        #1;
        chk_reset_state("rst0", 0);
        chk_reset_state("rst3", 1);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].d, vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Both masters request continuously, each dropping after 3 acks
`ifdef MEMARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 1, 1, 1};
`endif
        n  = 0;
        c0 = 0;
        c1 = 0;
        @(negedge clock);
        drive(0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
        for (int cyc = 0; cyc < 200 && n < 6; cyc++) begin
            @(posedge clock); #1;
            if (if0.m0_ack && n < 6) begin
                seq[n] = 0;
                n++;
                c0++;
                chk("simul_gnt_m0", if0.gnt_id, 0);
                chk("simul_rdata_m0", if0.rdata, 8'hA5);
                if (c0 == 3) drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            if (if0.m1_ack && n < 6) begin
                seq[n] = 1;
                n++;
                c1++;
                chk("simul_gnt_m1", if0.gnt_id, 1);
                chk("simul_rdata_m1", if0.rdata, 8'h77);
                if (c1 == 3) drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        chk("simul_ack_count", n, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < n) chk("simul_order", seq[i], exp_seq[i]);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clock);

        // Reset asserted mid-WAIT on the WAIT_STATES=3 instance
        @(negedge clock);
        drive(1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #3;
        chk("pre_reset_busy", if3.busy, 1);
        reset = 1'b0;
        #1;
        chk_reset_state("midrst3", 1);
        chk_reset_state("midrst0", 0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        chk("no_ack_after_reset", if3.m1_ack, 0);
        @(negedge clock);
        reset = 1'b1;
        txn(1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
